// File: rtl/dff_pkg.sv
// ============================================================================
// Module   : dff_pkg
// Brief    : Shared constants and helpers for the dff_pipe elastic pipeline.
//            DFF_PIPE_PARITY_EN sizes the per-stage parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dff_pkg;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 1024;

`ifdef DFF_PIPE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Even parity: the returned bit makes data plus parity hold an even count of ones.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dff_pipe_stage.sv
// ============================================================================
// Module   : dff_pipe_stage
// Brief    : One valid/data register of the elastic pipeline, with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_pipe_stage #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic         up_vld,
  input  logic [W-1:0] up_dat,
  output logic         vld,
  output logic [W-1:0] dat,
  output logic         vld_nxt
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  // Data only follows a real word, so bubbles never overwrite held contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= RST_VAL;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (load) begin
      r_vld <= up_vld;
      if (up_vld) begin
        r_dat <= up_dat;
      end
    end
  end

  always_comb begin
    vld_nxt = r_vld;
    if (flush) begin
      vld_nxt = 1'b0;
    end else if (load) begin
      vld_nxt = up_vld;
    end
  end

  assign vld = r_vld;
  assign dat = r_dat;

endmodule

`default_nettype wire

// File: rtl/dff_pipe.sv
// ============================================================================
// Module   : dff_pipe
// Brief    : Elastic WIDTH x DEPTH register pipeline with valid/ready, bubble
//            collapsing, freeze, flush and occupancy; DFF_PIPE_PARITY_EN adds parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [lvl_width(DEPTH)-1:0]   level,
  output logic                          out_par_err
);

  localparam int             LW          = lvl_width(DEPTH);
  localparam int             SW          = WIDTH + PAR_W;
  localparam logic [SW-1:0]  C_STAGE_RST = SW'(RST_VAL);

  logic [DEPTH:0]    w_rdy;
  logic [DEPTH-1:0]  w_vld;
  logic [DEPTH-1:0]  w_vld_nxt;
  logic [DEPTH-1:0]  w_load;
  logic [DEPTH-1:0]  w_up_vld;
  logic [SW-1:0]     w_up_dat [DEPTH];
  logic [SW-1:0]     w_dat    [DEPTH];
  logic [SW-1:0]     w_in_word;
  logic [LW-1:0]     w_cnt;
  logic [LW-1:0]     r_level;

`ifdef DFF_PIPE_PARITY_EN
  assign w_in_word = {even_par(PAR_MAX_W'(in_data)), in_data};
`else
  assign w_in_word = in_data;
`endif

  assign w_rdy[DEPTH] = out_ready;

  // Ready ripples back from the output so an empty stage always accepts.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign w_rdy[i]  = ~w_vld[i] | w_rdy[i+1];
    assign w_load[i] = w_rdy[i] & ena & ~clr;

    if (i == 0) begin : g_head
      assign w_up_vld[i] = in_valid;
      assign w_up_dat[i] = w_in_word;
    end else begin : g_body
      assign w_up_vld[i] = w_vld[i-1];
      assign w_up_dat[i] = w_dat[i-1];
    end

    dff_pipe_stage #(
      .W       (SW),
      .RST_VAL (C_STAGE_RST)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_load[i]),
      .flush   (clr),
      .up_vld  (w_up_vld[i]),
      .up_dat  (w_up_dat[i]),
      .vld     (w_vld[i]),
      .dat     (w_dat[i]),
      .vld_nxt (w_vld_nxt[i])
    );
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + LW'(w_vld_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      r_level <= w_cnt;
    end
  end

  assign in_ready  = w_rdy[0] & ena & ~clr;
  assign out_valid = w_vld[DEPTH-1] & ena;
  assign out_data  = w_dat[DEPTH-1][WIDTH-1:0];
  assign level     = r_level;

`ifdef DFF_PIPE_PARITY_EN
  assign out_par_err = out_valid & ((^out_data) != w_dat[DEPTH-1][WIDTH]);
`else
  assign out_par_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe.sv
// ============================================================================
// Module   : tb_dff_pipe
// Brief    : Self-checking bench for dff_pipe (WIDTH=8, DEPTH=3) against a
//            queue-of-words reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;
  logic             out_par_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: words in arrival order (index 0 oldest) and the stage each occupies.
  logic [WIDTH-1:0] mq_dat [$];
  int               mq_pos [$];
  logic [WIDTH-1:0] pend   [$];
  bit               last_acc;

  dff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .out_par_err (out_par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit ordy,
                       input bit en, input bit cl);
    bit exp_ir, exp_ov, took;
    int prev, p;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    ena       = en;
    clr       = cl;
    @(negedge clk);
    exp_ir = en && !cl && (mq_dat.size() < DEPTH || ordy);
    exp_ov = en && mq_dat.size() > 0 && mq_pos[0] == DEPTH-1;
    check("in_ready",  32'(in_ready),  32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check("out_data", 32'(out_data), 32'(mq_dat[0]));
    check("level",     32'(level),     32'(mq_dat.size()));
    check("par_err",   32'(out_par_err), 32'(0));
    last_acc = iv && exp_ir;
    if (cl) begin
      mq_dat.delete();
      mq_pos.delete();
    end else if (en) begin
      took = exp_ov && ordy;
      if (took) begin
        void'(mq_dat.pop_front());
        void'(mq_pos.pop_front());
      end
      // A word advances unless the slot ahead stays occupied this cycle.
      prev = DEPTH;
      for (int k = 0; k < mq_pos.size(); k++) begin
        p = mq_pos[k];
        if (prev > p + 1) p = p + 1;
        mq_pos[k] = p;
        prev = p;
      end
      if (last_acc) begin
        mq_dat.push_back(d);
        mq_pos.push_back(0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer pending words in order for n cycles, retrying until accepted.
  task automatic run(input int n, input bit ordy);
    for (int c = 0; c < n; c++) begin
      if (pend.size() > 0) begin
        cycle(1'b1, pend[0], ordy, 1'b1, 1'b0);
        if (last_acc) void'(pend.pop_front());
      end else begin
        cycle(1'b0, 8'h00, ordy, 1'b1, 1'b0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clr = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_level",     32'(level),     32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_par_err",   32'(out_par_err), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    pend = '{8'h11, 8'h22, 8'h33, 8'h44};
    run(10, 1'b1);

    pend = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run(6, 1'b0);
    run(10, 1'b1);

    cycle(1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    pend = '{8'hC1, 8'hC2};
    run(4, 1'b0);
    repeat (4) cycle(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    run(5, 1'b1);

    pend = '{8'hD1, 8'hD2, 8'hD3};
    run(3, 1'b0);
    cycle(1'b1, 8'hD4, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    pend.delete();

    for (int c = 0; c < 400; c++) begin
      cycle(1'($urandom % 2), 8'($urandom), ($urandom % 4) != 0,
            ($urandom % 10) != 0, ($urandom % 30) == 0);
    end
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

`ifdef DFF_PIPE_PARITY_EN
    pend = '{8'hE5};
    run(5, 1'b0);
    force dut.g_stage[DEPTH-1].u_stage.r_dat[0] = 1'b0;
    @(negedge clk);
    check("par_err_flip", 32'(out_par_err), 32'(1));
    ena = 1'b0;
    @(negedge clk);
    check("par_err_frozen", 32'(out_par_err), 32'(0));
    release dut.g_stage[DEPTH-1].u_stage.r_dat[0];
    ena = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    mq_dat.delete();
    mq_pos.delete();
    @(negedge clk);
    check("par_err_flushed", 32'(out_par_err), 32'(0));
    check("level_flushed",   32'(level),       32'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised elastic register pipeline; next generation of the team's single-bit enabled DFF.
- Moves WIDTH-bit words through DEPTH register stages with valid/ready handshake on both sides and bubble collapsing.
- Also provides a global enable (freeze), a synchronous flush and an occupancy count.
- Used wherever a timing-closure register slice or short elastic buffer is needed between streaming blocks.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- RST_VAL, '0, value loaded into every stage data register on reset.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- ena  input  1  active-high global enable; 0 freezes the whole pipeline.
- clr  input  1  active-high synchronous flush of all stages.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  pipeline can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  output word.
- level  output  $clog2(DEPTH+1)  number of occupied stages.
- out_par_err  output  1  parity error flag (see Optional Feature).

Behaviour:
- Stage 0 is input side; stage DEPTH-1 drives out_data/out_valid. Per-stage state: vld[i], dat[i].
- Reset (rst_n=0 at posedge): vld all 0, dat all RST_VAL, level=0, out_valid=0, out_par_err=0. Reset has priority over clr and ena.
- Ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i]=~vld[i] | rdy[i+1].
- in_ready = rdy[0] & ena & ~clr.
- out_valid = vld[DEPTH-1] & ena.
- Stage i loads from stage i-1 (or the input for i=0) when rdy[i] & ena & ~clr.
  - New vld[i] = vld[i-1] (or in_valid).
  - dat[i] loads only when the incoming valid is 1; otherwise dat holds.
- Bubble collapsing: an empty stage accepts even if downstream is stalled.
- Full with out_ready=0: in_ready=0, nothing moves.
- Full with out_ready=1: one word out, one in, same cycle.
- Latency: word accepted at cycle N appears with out_valid=1 at cycle N+DEPTH when empty and unstalled. Throughput 1 word/cycle.
- ena=0:
  - All vld/dat hold; level holds.
  - in_ready=0 and out_valid=0, so no transfer on either side.
- clr=1 (with rst_n=1): all vld cleared next edge, dat holds, level=0 next cycle. in_ready=0 that cycle. Takes effect regardless of ena.
- level: registered popcount of vld; updated every edge along with vld. Range 0..DEPTH, no wrap.
- Word ordering is strictly FIFO; no word is ever duplicated or dropped except by clr/rst_n.
- Reset or clr mid-stream discards all in-flight words; no partial state survives.

Optional Feature:
- Macro DFF_PIPE_PARITY_EN.
- Defined:
  - Each stage carries one extra even-parity bit computed from in_data at stage 0.
  - At the output, out_par_err = out_valid & (^out_data != stored parity).
  - Parity bit is reset to 0 along with RST_VAL data.
- Undefined: no parity storage; out_par_err is tied to 0. The port always exists.

Decomposition:
- Shared package dff_pkg:
  - function lvl_width(depth) returning $clog2(depth+1).
  - function even_par(data) used by the parity option.
  - Constant PAR_W (1 when DFF_PIPE_PARITY_EN is defined, else 0).
- Sub-module dff_pipe_stage:
  - Holds one vld/dat(/parity) register.
  - Inputs: load enable, flush, upstream valid/data.
  - dff_pipe instantiates DEPTH of them in a generate loop and builds the ready chain and level.

Test Plan:
- Reset with WIDTH=8, DEPTH=3: hold rst_n=0 two cycles -> out_valid=0, level=0, out_data=RST_VAL; in_ready=1 after release with ena=1.
- Stream 0x11,0x22,0x33,0x44 back-to-back with out_ready=1 -> 0x11 valid 3 cycles after acceptance, then one word per cycle in order, level stays 3 once primed.
- Backpressure: out_ready=0 while sending 0xA0..0xA4 -> after 3 accepts in_ready=0, level=3; raise out_ready -> outputs 0xA0,0xA1,0xA2 then 0xA3,0xA4, nothing lost.
- Bubbles: in_valid pattern 1,0,1 with out_ready=0 -> collapses to level=2 with words adjacent at output end; release yields them on consecutive cycles.
- ena=0 for 4 cycles mid-stream with level=2 -> in_ready=0, out_valid=0, level=2 held; after ena=1 the same words emerge unchanged. Then clr=1 for one cycle -> level=0, out_valid=0 next cycle.
- With DFF_PIPE_PARITY_EN: force a bit flip in stage DEPTH-1 data via bench -> out_par_err=1 exactly while that word is valid. Without the macro -> out_par_err always 0.
